// File: rtl/alu_seq_arbiter.sv
// Two-requester round-robin front end for a shared 8-bit adder.
// Each granted add/subtract is run one byte per cycle, LSB first.
module alu_seq_arbiter #(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  output logic         ack0,
  input  logic         req1,
  input  logic         op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] result,
  output logic         flag_c,
  output logic         flag_z,
  output logic         flag_v,
  output logic         flag_n
);

  // state  | meaning
  // S_IDLE | waiting for a request; the only state that grants
  // S_ADD  | one result byte per cycle, byte index idx
  // S_DONE | result and flags presented for one cycle
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t         state, state_nxt;
  logic   [W-1:0] a_reg, b_reg;
  logic           carry;
  logic           ptr;
  logic [IW-1:0]  idx;

  logic           gnt_valid, gnt_id;
  logic           op_sel;
  logic [W-1:0]   a_sel, b_sel;
  logic           last;
  logic [7:0]     a_byte, b_byte;
  logic [8:0]     sum9;
  logic [7:0]     sum7;
  logic           c7;
  logic [W-1:0]   res_nxt;

  // Ties go to the pointer; a lone requester wins regardless of it.
  assign gnt_valid = req0 | req1;
  assign gnt_id    = (req0 && req1) ? ptr : req1;
  assign op_sel    = gnt_id ? op1 : op0;
  assign a_sel     = gnt_id ? a1 : a0;
  assign b_sel     = gnt_id ? b1 : b0;

  assign last   = (idx == IW'(NBYTES - 1));
  assign a_byte = a_reg[8*idx +: 8];
  assign b_byte = b_reg[8*idx +: 8];
  assign sum9   = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry};
  // Carry into bit 7 of the top byte, needed for signed overflow.
  assign sum7   = {1'b0, a_byte[6:0]} + {1'b0, b_byte[6:0]} + {7'b0, carry};
  assign c7     = sum7[7];

  always_comb begin
    res_nxt = result;
    res_nxt[8*idx +: 8] = sum9[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (gnt_valid) state_nxt = S_ADD;
      S_ADD:   if (last)      state_nxt = S_DONE;
      S_DONE:                 state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Outputs are held low while rst is asserted so an aborted op never pulses.
  always_comb begin
    ack0 = 1'b0;
    ack1 = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          ack0 = gnt_valid & ~gnt_id;
          ack1 = gnt_valid &  gnt_id;
        end
        S_ADD:  busy = 1'b1;
        S_DONE: begin
          busy = 1'b1;
          done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      carry   <= 1'b0;
      ptr     <= 1'b0;
      idx     <= '0;
      done_id <= 1'b0;
      result  <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_v  <= 1'b0;
      flag_n  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            a_reg   <= a_sel;
            b_reg   <= op_sel ? ~b_sel : b_sel;
            carry   <= op_sel;
            done_id <= gnt_id;
            ptr     <= ~gnt_id;
            idx     <= '0;
          end
        end
        S_ADD: begin
          result <= res_nxt;
          carry  <= sum9[8];
          idx    <= idx + IW'(1);
          if (last) begin
            flag_c <= sum9[8];
            flag_z <= (res_nxt == '0);
            flag_v <= sum9[8] ^ c7;
            flag_n <= res_nxt[W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Self-checking bench for alu_seq_arbiter: directed vectors, random ops,
// contention alternation and mid-operation reset against a wide-arithmetic model.
module tb_alu_seq_arbiter;
  localparam int N = 4;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, op0, req1, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, busy, done, done_id;
  logic [W-1:0] result;
  logic         flag_c, flag_z, flag_v, flag_n;

  int tests = 0;
  int fails = 0;

  alu_seq_arbiter #(.NBYTES(N)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
    .busy(busy), .done(done), .done_id(done_id), .result(result),
    .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: whole-word arithmetic; flags as {C,Z,V,N}.
  function automatic void ref_alu(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [3:0] f);
    logic [W:0]   full;
    logic [W-1:0] bb;
    bb   = op ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(op);
    r    = full[W-1:0];
    f[3] = full[W];
    f[2] = (r == '0);
    f[1] = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    f[0] = r[W-1];
  endfunction

  task automatic do_op(input bit k, input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [3:0] f, output logic id,
                       output int lat, output bit ok);
    int w;
    ok = 0; lat = 0; r = '0; f = '0; id = 1'b0;
    @(posedge clk); #1;
    if (k) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
    else   begin req0 = 1; op0 = op; a0 = a; b0 = b; end
    for (w = 0; w < 20; w++) begin
      @(negedge clk);
      if (k ? ack1 : ack0) break;
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    op0 = 1'($urandom_range(0, 1)); op1 = 1'($urandom_range(0, 1));
    if (w == 20) return;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (done) break;
    end
    if (lat > 20) return;
    r = result; f = {flag_c, flag_z, flag_v, flag_n}; id = done_id; ok = 1;
  endtask

  task automatic test_reset();
    rst = 1; req0 = 1; req1 = 1; op0 = 0; op1 = 0;
    a0 = 32'h1234_5678; b0 = 32'h1; a1 = 32'h5; b1 = 32'h6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({ack0, ack1, busy, done, done_id, flag_c, flag_z, flag_v, flag_n, result} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ack0=%b ack1=%b busy=%b done=%b id=%b flags=%b%b%b%b result=%h, want all 0",
               ack0, ack1, busy, done, done_id, flag_c, flag_z, flag_v, flag_n, result);
    end
    @(posedge clk); #1;
    rst = 0; req0 = 0; req1 = 0;
  endtask

  task automatic test_directed();
    bit           kk[5]  = '{0, 1, 0, 1, 1};
    bit           oo[5]  = '{0, 0, 0, 1, 1};
    logic [W-1:0] av[5]  = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h0000_0003};
    logic [W-1:0] bv[5]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0005, 32'h0000_0005};
    logic [W-1:0] rv[5]  = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFE};
    logic [3:0]   fv[5]  = '{4'b0000, 4'b1100, 4'b0011, 4'b1100, 4'b0001};
    logic [W-1:0] r;
    logic [3:0]   f;
    logic         id;
    int           lat;
    bit           ok;
    for (int i = 0; i < 5; i++) begin
      do_op(kk[i], oo[i], av[i], bv[i], r, f, id, lat, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL directed_%0d_timeout: got no ack/done, want done %0d cycles after ack", i, N + 1);
        continue;
      end
      tests++;
      if (lat !== N + 1) begin
        fails++;
        $display("FAIL directed_%0d_latency: got %0d, want %0d", i, lat, N + 1);
      end
      tests++;
      if (r !== rv[i]) begin
        fails++;
        $display("FAIL directed_%0d_result: got %h, want %h", i, r, rv[i]);
      end
      tests++;
      if (f !== fv[i]) begin
        fails++;
        $display("FAIL directed_%0d_flags_czvn: got %b, want %b", i, f, fv[i]);
      end
      tests++;
      if (id !== kk[i]) begin
        fails++;
        $display("FAIL directed_%0d_done_id: got %b, want %b", i, id, kk[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, er;
    logic [3:0]   f, ef;
    logic         id;
    bit           k, op, ok;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      k  = 1'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
      a  = $urandom; b = $urandom;
      case ($urandom_range(0, 3))
        1: b = a;
        2: begin a = '1; b = 32'($urandom_range(0, 2)); end
        3: begin a = 32'h8000_0000; b = 32'h7FFF_FFFF; end
        default: ;
      endcase
      ref_alu(op, a, b, er, ef);
      do_op(k, op, a, b, r, f, id, lat, ok);
      tests++;
      if (!ok || lat !== N + 1 || {id, f, r} !== {k, ef, er}) begin
        fails++;
        $display("FAIL random_%0d: got ok=%b lat=%0d id=%b czvn=%b result=%h, want lat=%0d id=%b czvn=%b result=%h (op=%b a=%h b=%h)",
                 i, ok, lat, id, f, r, N + 1, k, ef, er, op, a, b);
      end
    end
  endtask

  task automatic test_contention();
    int           ack_cyc[$];
    bit           ack_who[$];
    bit           done_who[$];
    int           overlaps = 0;
    int           bad_res = 0;
    logic [W-1:0] er0, er1;
    logic [3:0]   ef0, ef1;
    @(posedge clk); #1;
    rst = 1; req0 = 1; req1 = 1;
    op0 = 0; a0 = 32'h0102_0304; b0 = 32'h1111_1111;
    op1 = 1; a1 = 32'h0000_0010; b1 = 32'h0000_0020;
    ref_alu(0, a0, b0, er0, ef0);
    ref_alu(1, a1, b1, er1, ef1);
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 3 * (N + 2); c++) begin
      @(negedge clk);
      if (ack0 && ack1) overlaps++;
      if (ack0 || ack1) begin ack_cyc.push_back(c); ack_who.push_back(ack1); end
      if (done) begin
        done_who.push_back(done_id);
        if ({flag_c, flag_z, flag_v, flag_n, result} !== (done_id ? {ef1, er1} : {ef0, er0})) bad_res++;
      end
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    tests++;
    if (overlaps != 0) begin
      fails++;
      $display("FAIL contention_ack_overlap: got %0d overlapping cycles, want 0", overlaps);
    end
    tests++;
    if (ack_cyc.size() != 3 || done_who.size() != 3) begin
      fails++;
      $display("FAIL contention_counts: got %0d acks %0d dones, want 3 and 3", ack_cyc.size(), done_who.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (ack_cyc[i] != i * (N + 2) || ack_who[i] != 1'(i % 2) || done_who[i] != 1'(i % 2)) begin
          fails++;
          $display("FAIL contention_grant_%0d: got cycle %0d ack_id %b done_id %b, want cycle %0d id %b",
                   i, ack_cyc[i], ack_who[i], done_who[i], i * (N + 2), 1'(i % 2));
        end
      end
    end
    tests++;
    if (bad_res != 0) begin
      fails++;
      $display("FAIL contention_results: got %0d wrong results, want 0", bad_res);
    end
  endtask

  task automatic test_reset_mid();
    int           w;
    int           dones = 0;
    int           done_at = -1;
    logic         id_at = 1'b1;
    logic [W-1:0] r_at = '0;
    logic [W-1:0] er;
    logic [3:0]   ef;
    @(posedge clk); #1;
    req0 = 1; op0 = 0; a0 = 32'h1234_5678; b0 = 32'h1111_1111;
    for (w = 0; w < 20; w++) begin
      @(negedge clk);
      if (ack0) break;
    end
    tests++;
    if (w == 20) begin
      fails++;
      $display("FAIL rstmid_ack_timeout: got no ack0, want ack0");
      req0 = 0;
      return;
    end
    @(posedge clk); #1;
    req0 = 0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; req0 = 1; req1 = 1;
    op0 = 1; a0 = 32'h0000_1000; b0 = 32'h0000_0001;
    op1 = 0; a1 = 32'h0000_0002; b1 = 32'h0000_0003;
    ref_alu(1, a0, b0, er, ef);
    @(negedge clk);
    tests++;
    if ({busy, done, result, flag_c, flag_z, flag_v, flag_n} !== '0) begin
      fails++;
      $display("FAIL rstmid_cleared: got busy=%b done=%b result=%h flags=%b%b%b%b, want all 0",
               busy, done, result, flag_c, flag_z, flag_v, flag_n);
    end
    tests++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_pointer: got ack0=%b ack1=%b, want ack0=1 ack1=0", ack0, ack1);
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    for (int c = 1; c <= N + 3; c++) begin
      @(negedge clk);
      if (done) begin dones++; done_at = c; id_at = done_id; r_at = result; end
    end
    tests++;
    if (dones != 1 || done_at != N + 1 || id_at !== 1'b0 || r_at !== er) begin
      fails++;
      $display("FAIL rstmid_next_op: got %0d dones at %0d id %b result %h, want 1 done at %0d id 0 result %h",
               dones, done_at, id_at, r_at, N + 1, er);
    end
  endtask

  initial begin
    rst = 1; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_directed();
    test_random();
    test_contention();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq_arbiter.md
Name: alu_seq_arbiter

Overview:
- Shares one 8-bit byte adder between two requesters and performs multi-byte add/subtract on it.
- The block arbitrates round-robin, captures the winner's operands, and runs one byte per cycle from LSB to MSB. Carry is chained through a carry register.
- On completion it delivers the full result and flags C, Z, V, N.
- It sits between client blocks and the shared 8-bit ALU datapath, so wide arithmetic needs no wide adder.

Parameters:
- NBYTES, 4, number of bytes per operand (range 1..16); operand width W = 8*NBYTES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req0  input  1  requester 0 wants an operation; level, held until ack0.
- op0  input  1  requester 0 op: 0 = A+B, 1 = A-B.
- a0  input  W  requester 0 operand A.
- b0  input  W  requester 0 operand B.
- ack0  output  1  one-cycle pulse; req0 accepted, operands captured this cycle.
- req1, op1, a1, b1, ack1: same as the requester 0 ports, for requester 1.
- busy  output  1  high from the cycle after an ack through the done cycle.
- done  output  1  one-cycle pulse; result and flags valid.
- done_id  output  1  index of the requester that owns the current result.
- result  output  W  sum or difference.
- flag_c  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- flag_z  output  1  1 when result == 0.
- flag_v  output  1  signed overflow = carry into bit W-1 XOR carry out of bit W-1.
- flag_n  output  1  result[W-1].

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = 0 (requester 0 preferred); carry reg 0.
- States:
  - IDLE: grants only here. Transition to ADD on a grant.
  - ADD: byte counter i = 0..NBYTES-1. Transition to DONE after byte NBYTES-1.
  - DONE: one cycle, then IDLE.
- Arbitration in IDLE:
  - Only reqK high: grant K.
  - Both high: grant the pointer's index.
  - After every grant the pointer = the other index (strict alternation under contention).
  - Neither high: stay IDLE.
- Grant cycle T:
  - ackK = 1.
  - Capture aK, bK, opK, done_id = K.
  - Carry reg = opK; B is inverted when opK = 1 (A + ~B + 1).
- ADD cycle T+1+i:
  - sum9 = A[8i+7:8i] + B'[8i+7:8i] + carry.
  - Write result byte i; carry = sum9[8].
  - At i = NBYTES-1, also record the carry into bit 7 of that byte for V.
- DONE at cycle T+NBYTES+1:
  - done = 1.
  - Flags computed from the final result and carries.
  - Earliest next ack at T+NBYTES+2. Throughput is one op per NBYTES+2 cycles.
- result, flags and done_id hold until the next DONE overwrites them. Result bytes update during ADD, so they are valid only when done = 1.
- Operand inputs are ignored outside the grant cycle. A requester may change them after ack.
- A req still high after its ack is treated as a new request at the next IDLE.
- Requests raised during busy are not acked until IDLE; there is no queueing.
- ack0 and ack1 are never high together; ack is never high when state is not IDLE.
- rst mid-operation: abort the operation, no done pulse, all outputs to reset values, pointer = 0.
- NBYTES = 1: ADD lasts one cycle; behaviour otherwise identical.

Test Plan (NBYTES = 4):
- req0, op0 = 0, a0 = 0x000000FF, b0 = 0x00000001 -> ack0 at T; done at T+5; result 0x00000100; C0 Z0 V0 N0; done_id 0.
- req1 add 0xFFFFFFFF + 0x00000001 -> result 0x00000000; C1 Z1 V0 N0; done_id 1.
- req0 add 0x7FFFFFFF + 0x00000001 -> result 0x80000000; V1 N1 C0 Z0.
- req1 sub 0x00000005 - 0x00000005 -> result 0; C1 Z1. Sub 3 - 5 -> result 0xFFFFFFFE; C0 N1 V0.
- req0 and req1 both high continuously from reset -> ack0 at T, ack1 at T+6, ack0 at T+12; done_id alternates 0, 1, 0; acks never overlap.
- rst pulsed during ADD byte 2 -> next cycle busy = 0, result = 0, no done pulse. A new req0 is then acked in the first IDLE cycle after rst deasserts, with pointer 0 winning any tie.
